// File: rtl/ula_multiciclo.sv
// Multi-cycle execute unit: single-cycle ALU ops, 32-cycle shift-add multiply, optional
// 32-cycle restoring divide (compiled in when ULA_DIV_EN is defined).
module ula_multiciclo (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] regR1,
  input  logic [31:0] regR2,
  input  logic [4:0]  add_regD_in,
  output logic [31:0] result,
  output logic [4:0]  add_regD,
  output logic [1:0]  UC_out,
  output logic        busy,
  output logic        zero,
  output logic        erro
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  localparam logic [1:0] WR_EN  = 2'b01;
  localparam logic [1:0] WR_OFF = 2'b00;

  state_t      state;
  logic [4:0]  counter;
  logic [4:0]  dest;
  // MUL: opnd_a = multiplicand (shifts left), opnd_b = multiplier (shifts right), acc = partial sum.
  // DIV: opnd_a = dividend shifting out / quotient shifting in, opnd_b = divisor, acc = remainder.
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic [31:0] acc;

  logic [31:0] simple_res;
  logic [31:0] mul_acc_next;

  always_comb begin
    simple_res = '0;
    case (op)
      OP_ADD:  simple_res = regR1 + regR2;
      OP_SUB:  simple_res = regR1 - regR2;
      OP_AND:  simple_res = regR1 & regR2;
      OP_OR:   simple_res = regR1 | regR2;
      OP_XOR:  simple_res = regR1 ^ regR2;
      OP_SLT:  simple_res = {31'd0, ($signed(regR1) < $signed(regR2))};
      default: simple_res = '0;
    endcase
  end

  assign mul_acc_next = acc + (opnd_b[0] ? opnd_a : 32'd0);

`ifdef ULA_DIV_EN
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        quo_bit;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  // A non-negative trial difference means the divisor fits: keep it and shift in a 1.
  always_comb begin
    rem_shift = {acc, opnd_a[31]};
    rem_diff  = rem_shift - {1'b0, opnd_b};
    quo_bit   = ~rem_diff[32];
    rem_next  = quo_bit ? rem_diff[31:0] : rem_shift[31:0];
    quo_next  = {opnd_a[30:0], quo_bit};
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      dest     <= '0;
      opnd_a   <= '0;
      opnd_b   <= '0;
      acc      <= '0;
      result   <= '0;
      add_regD <= '0;
      UC_out   <= WR_OFF;
      busy     <= 1'b0;
      zero     <= 1'b0;
      erro     <= 1'b0;
    end else begin
      UC_out <= WR_OFF;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (op == OP_MUL) begin
              dest    <= add_regD_in;
              opnd_a  <= regR1;
              opnd_b  <= regR2;
              acc     <= '0;
              counter <= '0;
              state   <= MUL;
            end else if (op == OP_DIV) begin
`ifdef ULA_DIV_EN
              if (regR2 == 32'd0) begin
                result   <= 32'hFFFF_FFFF;
                add_regD <= add_regD_in;
                zero     <= 1'b0;
                erro     <= 1'b1;
                UC_out   <= WR_EN;
                state    <= DONE;
              end else begin
                dest    <= add_regD_in;
                opnd_a  <= regR1;
                opnd_b  <= regR2;
                acc     <= '0;
                counter <= '0;
                state   <= DIV;
              end
`else
              // No divider: flag the error but suppress the bank writeback.
              result   <= '0;
              add_regD <= add_regD_in;
              zero     <= 1'b1;
              erro     <= 1'b1;
              state    <= DONE;
`endif
            end else begin
              result   <= simple_res;
              add_regD <= add_regD_in;
              zero     <= (simple_res == 32'd0);
              erro     <= 1'b0;
              UC_out   <= WR_EN;
              state    <= DONE;
            end
          end
        end

        MUL: begin
          acc     <= mul_acc_next;
          opnd_a  <= {opnd_a[30:0], 1'b0};
          opnd_b  <= {1'b0, opnd_b[31:1]};
          counter <= counter + 5'd1;
          if (counter == 5'd31) begin
            result   <= mul_acc_next;
            add_regD <= dest;
            zero     <= (mul_acc_next == 32'd0);
            erro     <= 1'b0;
            UC_out   <= WR_EN;
            counter  <= '0;
            state    <= DONE;
          end
        end

        DIV: begin
`ifdef ULA_DIV_EN
          acc     <= rem_next;
          opnd_a  <= quo_next;
          counter <= counter + 5'd1;
          if (counter == 5'd31) begin
            result   <= quo_next;
            add_regD <= dest;
            zero     <= (quo_next == 32'd0);
            erro     <= 1'b0;
            UC_out   <= WR_EN;
            counter  <= '0;
            state    <= DONE;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          erro  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: randomized commands checked against an arithmetic
// reference model; honours ULA_DIV_EN the same way as the design.
module tb_ula_multiciclo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] regR1 = '0;
  logic [31:0] regR2 = '0;
  logic [4:0]  add_regD_in = '0;
  logic [31:0] result;
  logic [4:0]  add_regD;
  logic [1:0]  UC_out;
  logic        busy;
  logic        zero;
  logic        erro;

  int passed = 0;
  int total  = 0;

  ula_multiciclo dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .regR1(regR1), .regR2(regR2), .add_regD_in(add_regD_in),
    .result(result), .add_regD(add_regD), .UC_out(UC_out),
    .busy(busy), .zero(zero), .erro(erro)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_alu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return prod[31:0];
      default: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  // Leaves time at 1ns after the accepting edge with start dropped.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    for (int i = 0; i < 40 && busy !== 1'b0; i++) begin
      @(posedge clock); #1;
    end
    if (busy !== 1'b0) begin
      total++;
      $display("[TB] FAIL idle_wait: busy=%b want 0", busy);
    end
    @(negedge clock);
    op = o; regR1 = a; regR2 = b; add_regD_in = d; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Edges after the accepting edge until UC_out==01 is seen; 41 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (UC_out !== 2'b01 && lat <= 40) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({result, add_regD, UC_out, busy, zero, erro} !== 42'd0)
      $display("[TB] FAIL reset_state: got res=%h dst=%0d uc=%b busy=%b z=%b e=%b want all 0",
               result, add_regD, UC_out, busy, zero, erro);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_simple;
    int lat;
    logic [2:0]  o;
    logic [31:0] a, b, exp;
    logic [4:0]  d;
    issue(3'd0, 32'hFFFF_FFFF, 32'd1, 5'd5);
    wait_done(lat);
    total++;
    if (lat !== 0 || result !== 32'd0 || zero !== 1'b1 || add_regD !== 5'd5 || busy !== 1'b1)
      $display("[TB] FAIL add_wrap: lat=%0d res=%h z=%b dst=%0d busy=%b want 0/0/1/5/1", lat, result, zero, add_regD, busy);
    else passed++;
    @(posedge clock); #1;
    total++;
    if (UC_out !== 2'b00 || busy !== 1'b0 || result !== 32'd0 || add_regD !== 5'd5)
      $display("[TB] FAIL add_after: uc=%b busy=%b res=%h dst=%0d want 00/0/0/5", UC_out, busy, result, add_regD);
    else passed++;

    issue(3'd5, 32'hFFFF_FFFF, 32'd1, 5'd9);
    wait_done(lat);
    total++;
    if (lat !== 0 || result !== 32'd1 || zero !== 1'b0)
      $display("[TB] FAIL slt_neg: lat=%0d res=%h z=%b want 0/1/0", lat, result, zero);
    else passed++;
    issue(3'd5, 32'd1, 32'hFFFF_FFFF, 5'd9);
    wait_done(lat);
    total++;
    if (lat !== 0 || result !== 32'd0 || zero !== 1'b1)
      $display("[TB] FAIL slt_swap: lat=%0d res=%h z=%b want 0/0/1", lat, result, zero);
    else passed++;

    for (int n = 0; n < 24; n++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      d = 5'($urandom);
      exp = ref_alu(o, a, b);
      issue(o, a, b, d);
      wait_done(lat);
      total++;
      if (lat !== 0 || result !== exp || add_regD !== d || zero !== (exp == 32'd0) || erro !== 1'b0)
        $display("[TB] FAIL simple_rand op=%0d a=%h b=%h: lat=%0d res=%h dst=%0d z=%b e=%b want 0/%h/%0d/%b/0",
                 o, a, b, lat, result, add_regD, zero, erro, exp, d, (exp == 32'd0));
      else passed++;
    end
  endtask

  task automatic test_mul;
    int lat;
    logic [31:0] a, b, exp;
    issue(3'd6, 32'd7, 32'd6, 5'd3);
    total++;
    if (busy !== 1'b1 || UC_out !== 2'b00)
      $display("[TB] FAIL mul_busy: busy=%b uc=%b want 1/00", busy, UC_out);
    else passed++;
    wait_done(lat);
    total++;
    if (lat !== 32 || result !== 32'd42 || add_regD !== 5'd3 || zero !== 1'b0 || busy !== 1'b1)
      $display("[TB] FAIL mul_7x6: lat=%0d res=%0d dst=%0d z=%b busy=%b want 32/42/3/0/1", lat, result, add_regD, zero, busy);
    else passed++;
    @(posedge clock); #1;
    total++;
    if (UC_out !== 2'b00 || busy !== 1'b0)
      $display("[TB] FAIL mul_single_pulse: uc=%b busy=%b want 00/0", UC_out, busy);
    else passed++;

    issue(3'd6, 32'h0001_0000, 32'h0001_0000, 5'd4);
    wait_done(lat);
    total++;
    if (lat !== 32 || result !== 32'd0 || zero !== 1'b1)
      $display("[TB] FAIL mul_overflow: lat=%0d res=%h z=%b want 32/0/1", lat, result, zero);
    else passed++;

    for (int n = 0; n < 4; n++) begin
      a = $urandom; b = $urandom;
      exp = ref_alu(3'd6, a, b);
      issue(3'd6, a, b, 5'd17);
      wait_done(lat);
      total++;
      if (lat !== 32 || result !== exp || add_regD !== 5'd17)
        $display("[TB] FAIL mul_rand a=%h b=%h: lat=%0d res=%h dst=%0d want 32/%h/17", a, b, lat, result, add_regD, exp);
      else passed++;
    end
  endtask

  task automatic test_div;
    int lat;
    int pulses;
    logic [31:0] a, b, exp;
`ifdef ULA_DIV_EN
    issue(3'd7, 32'd100, 32'd7, 5'd8);
    wait_done(lat);
    total++;
    if (lat !== 32 || result !== 32'd14 || add_regD !== 5'd8 || erro !== 1'b0)
      $display("[TB] FAIL div_100_7: lat=%0d res=%0d dst=%0d e=%b want 32/14/8/0", lat, result, add_regD, erro);
    else passed++;
    issue(3'd7, 32'd5, 32'd0, 5'd2);
    wait_done(lat);
    total++;
    if (lat !== 0 || result !== 32'hFFFF_FFFF || erro !== 1'b1 || add_regD !== 5'd2)
      $display("[TB] FAIL div_by_zero: lat=%0d res=%h e=%b dst=%0d want 0/ffffffff/1/2", lat, result, erro, add_regD);
    else passed++;
    for (int n = 0; n < 4; n++) begin
      a = $urandom;
      b = (n < 2) ? 32'($urandom_range(1, 1000)) : $urandom | 32'd1;
      exp = ref_alu(3'd7, a, b);
      issue(3'd7, a, b, 5'd21);
      wait_done(lat);
      total++;
      if (lat !== 32 || result !== exp || zero !== (exp == 32'd0))
        $display("[TB] FAIL div_rand a=%h b=%h: lat=%0d res=%h z=%b want 32/%h", a, b, lat, result, zero, exp);
      else passed++;
    end
`else
    issue(3'd0, 32'd1, 32'd1, 5'd1);
    wait_done(lat);
    issue(3'd7, 32'd100, 32'd7, 5'd8);
    total++;
    if (erro !== 1'b1 || busy !== 1'b1 || UC_out !== 2'b00 || result !== 32'd0)
      $display("[TB] FAIL div_disabled: e=%b busy=%b uc=%b res=%h want 1/1/00/0", erro, busy, UC_out, result);
    else passed++;
    pulses = 0;
    for (int c = 0; c < 36; c++) begin
      @(posedge clock); #1;
      if (UC_out === 2'b01) pulses++;
    end
    total++;
    if (pulses !== 0 || busy !== 1'b0)
      $display("[TB] FAIL div_disabled_nowb: pulses=%0d busy=%b want 0/0", pulses, busy);
    else passed++;
`endif
  endtask

  task automatic test_start_while_busy;
    int lat;
    int pulses;
    logic [31:0] res_seen;
    logic [4:0]  dst_seen;
    logic [31:0] exp;
    exp = ref_alu(3'd6, 32'd123457, 32'd789);
    issue(3'd6, 32'd123457, 32'd789, 5'd12);
    lat = -1; pulses = 0; res_seen = '0; dst_seen = '0;
    for (int c = 1; c <= 45; c++) begin
      if (lat < 0) begin
        @(negedge clock);
        start = 1'b1; op = 3'($urandom); regR1 = $urandom; regR2 = $urandom; add_regD_in = 5'($urandom);
      end
      @(posedge clock); #1;
      if (UC_out === 2'b01) begin
        pulses++;
        if (lat < 0) begin
          lat = c; res_seen = result; dst_seen = add_regD; start = 1'b0;
        end
      end
    end
    start = 1'b0;
    total++;
    if (pulses !== 1 || lat !== 32 || res_seen !== exp || dst_seen !== 5'd12)
      $display("[TB] FAIL start_while_busy: pulses=%0d lat=%0d res=%h dst=%0d want 1/32/%h/12", pulses, lat, res_seen, dst_seen, exp);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int lat;
    int pulses;
    issue(3'd0, 32'd20, 32'd22, 5'd7);
    wait_done(lat);
    issue(3'd6, 32'd9, 32'd9, 5'd6);
    repeat (10) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    total++;
    if ({result, add_regD, UC_out, busy, zero, erro} !== 42'd0)
      $display("[TB] FAIL reset_mid: res=%h dst=%0d uc=%b busy=%b z=%b e=%b want all 0", result, add_regD, UC_out, busy, zero, erro);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 36; c++) begin
      @(posedge clock); #1;
      if (UC_out === 2'b01) pulses++;
    end
    total++;
    if (pulses !== 0 || busy !== 1'b0)
      $display("[TB] FAIL reset_abort: pulses=%0d busy=%b want 0/0", pulses, busy);
    else passed++;
    issue(3'd0, 32'd2, 32'd3, 5'd1);
    wait_done(lat);
    total++;
    if (lat !== 0 || result !== 32'd5 || add_regD !== 5'd1)
      $display("[TB] FAIL reset_then_add: lat=%0d res=%0d dst=%0d want 0/5/1", lat, result, add_regD);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] a, b, first;
    a = $urandom; b = $urandom;
    first = ref_alu(3'd4, a, b);
    issue(3'd4, a, b, 5'd30);
    wait_done(lat);
    @(negedge clock);
    op = 3'd1; regR1 = b; regR2 = a; add_regD_in = 5'd31; start = 1'b1;
    @(posedge clock); #1;
    total++;
    if (UC_out !== 2'b00 || busy !== 1'b0 || result !== first || add_regD !== 5'd30)
      $display("[TB] FAIL b2b_gap: uc=%b busy=%b res=%h dst=%0d want 00/0/%h/30", UC_out, busy, result, add_regD, first);
    else passed++;
    @(posedge clock); #1;
    start = 1'b0;
    total++;
    if (UC_out !== 2'b01 || result !== ref_alu(3'd1, b, a) || add_regD !== 5'd31)
      $display("[TB] FAIL b2b_second: uc=%b res=%h dst=%0d want 01/%h/31", UC_out, result, add_regD, ref_alu(3'd1, b, a));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_simple();
    test_mul();
    test_div();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
